// File: rtl/imem_loader.sv
// imem_loader: byte-serial boot loader for the instruction memory.
// Packs MSB-first bytes into 32-bit words and writes them to the memory.
// Zero-fills the unloaded tail of the memory, then holds START high until reload.
//
// state | meaning
// IDLE  | one cycle after reset, then LOAD
// LOAD  | accepting program bytes, writing completed words
// CLEAR | writing zeros from wr_ptr up to IM_DEPTH-1
// DONE  | START high, waiting for reload
module imem_loader #(
    parameter int IM_DEPTH = 32,
    parameter int ADDR_W   = 5,
    parameter int INSTR_W  = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               reload,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               START,
    output logic [ADDR_W:0]    word_count,
    output logic               err_partial,
    output logic               err_ovf
);

    typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;

    localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(IM_DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(IM_DEPTH);

    state_t              state;
    logic [1:0]          byte_cnt;
    logic [INSTR_W-1:0]  asm_word;
    logic [ADDR_W-1:0]   wr_ptr;

    logic [INSTR_W-1:0]  keep_mask;
    logic [INSTR_W-1:0]  merged;
    logic                accept;
    logic                word_end;
    logic                at_top;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && (state == LOAD);
    assign word_end = accept && (in_last || (byte_cnt == 2'd3));
    assign at_top   = (wr_ptr == TOP);

    // Merge the incoming byte into the word; bytes below it read as zero,
    // which gives the padding for a short final word for free.
    always_comb begin
        keep_mask = '0;
        case (byte_cnt)
            2'd0:    keep_mask = 32'h0000_0000;
            2'd1:    keep_mask = 32'hFF00_0000;
            2'd2:    keep_mask = 32'hFFFF_0000;
            default: keep_mask = 32'hFFFF_FF00;
        endcase
        merged = (asm_word & keep_mask) | ({in_data, 24'd0} >> {byte_cnt, 3'b000});
    end

    // Loader FSM with registered memory port, START and status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            asm_word    <= '0;
            wr_ptr      <= '0;
            word_count  <= '0;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            START       <= 1'b0;
            err_partial <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE: state <= LOAD;
                LOAD: begin
                    if (accept) begin
                        asm_word <= merged;
                        byte_cnt <= word_end ? 2'd0 : byte_cnt + 2'd1;
                        if (word_end) begin
                            im_we    <= 1'b1;
                            im_addr  <= wr_ptr;
                            im_wdata <= merged;
                            if (word_count != FULL)
                                word_count <= word_count + (ADDR_W + 1)'(1);
                            if (in_last && (byte_cnt != 2'd3))
                                err_partial <= 1'b1;
                            // The pointer never wraps: the top address always ends loading.
                            if (at_top) begin
                                state <= DONE;
                                if (!in_last)
                                    err_ovf <= 1'b1;
                            end else begin
                                wr_ptr <= wr_ptr + ADDR_W'(1);
                                if (in_last)
                                    state <= CLEAR;
                            end
                        end
                    end
                end
                CLEAR: begin
                    im_we    <= 1'b1;
                    im_addr  <= wr_ptr;
                    im_wdata <= '0;
                    if (at_top)
                        state <= DONE;
                    else
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                DONE: begin
                    if (reload) begin
                        state       <= LOAD;
                        START       <= 1'b0;
                        wr_ptr      <= '0;
                        word_count  <= '0;
                        byte_cnt    <= 2'd0;
                        asm_word    <= '0;
                        err_partial <= 1'b0;
                        err_ovf     <= 1'b0;
                    end else begin
                        START <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed programs plus randomized
// byte gaps/contents, compared against a word-level model of the load.
module tb_imem_loader;

    localparam int IM_DEPTH = 32;
    localparam int ADDR_W   = 5;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_last = 1'b0;
    logic              reload = 1'b0;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              START;
    logic [ADDR_W:0]   word_count;
    logic              err_partial;
    logic              err_ovf;

    imem_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W), .INSTR_W(32)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .reload(reload),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .START(START), .word_count(word_count),
        .err_partial(err_partial), .err_ovf(err_ovf)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // captured memory-port activity
    logic [31:0] mem_cap [IM_DEPTH];
    int          wr_cyc  [IM_DEPTH];
    int          wr_count;
    int          start_rise;
    logic        start_prev = 1'b0;
    bit          seen10;
    int          last_acc_cyc;

    // reference model results
    logic [7:0]  prog [$];
    logic [31:0] exp_mem [IM_DEPTH];
    int          exp_wc, exp_acc, exp_k;
    bit          exp_partial, exp_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (!RST && im_we) begin
            mem_cap[im_addr] = im_wdata;
            wr_cyc[im_addr]  = cyc;
            wr_count++;
            if (im_addr == 5'd10) seen10 = 1'b1;
        end
        if (START && !start_prev && start_rise < 0) start_rise = cyc;
        start_prev = START;
    endtask

    task automatic push_word(input logic [31:0] w);
        prog.push_back(w[31:24]);
        prog.push_back(w[23:16]);
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
    endtask

    // Word-level view of a load: bytes pack MSB first into consecutive words,
    // the memory holds at most IM_DEPTH words, everything else reads zero.
    task automatic model(input bit has_last);
        int n;
        n = prog.size();
        for (int i = 0; i < IM_DEPTH; i++) exp_mem[i] = 32'd0;
        if (n > 4 * IM_DEPTH || (n == 4 * IM_DEPTH && !has_last)) begin
            exp_ovf = 1'b1;
            exp_acc = 4 * IM_DEPTH;
        end else begin
            exp_ovf = 1'b0;
            exp_acc = n;
        end
        exp_wc      = (exp_acc + 3) / 4;
        exp_k       = exp_wc - 1;
        exp_partial = !exp_ovf && (exp_acc % 4 != 0);
        for (int i = 0; i < exp_acc; i++)
            exp_mem[i / 4] = exp_mem[i / 4] | (32'(prog[i]) << (24 - 8 * (i % 4)));
    endtask

    // gap_mode: 0 = back-to-back, 1 = alternate idle cycles, 2 = random idles
    // (with ignored reload pulses sprinkled into the idle cycles).
    task automatic send_bytes(input bit has_last, input int gap_mode);
        int  n, idx, acc, stall;
        bit  toggle, gap, chk_next;
        for (int i = 0; i < IM_DEPTH; i++) begin
            mem_cap[i] = 32'hDEAD_BEEF;
            wr_cyc[i]  = -1;
        end
        wr_count   = 0;
        start_rise = -1;
        seen10     = 1'b0;
        model(has_last);
        n = prog.size();
        idx = 0; acc = 0; stall = 0; toggle = 1'b0; chk_next = 1'b0;
        while (idx < n && stall < 8) begin
            tick();
            if (chk_next) begin
                check("in_ready_after_last", in_ready, 1'b0);
                chk_next = 1'b0;
            end
            case (gap_mode)
                1:       gap = toggle;
                2:       gap = ($urandom_range(0, 99) < 40);
                default: gap = 1'b0;
            endcase
            toggle = ~toggle;
            if (gap) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'($urandom);
                reload   = (gap_mode == 2) && ($urandom_range(0, 3) == 0);
            end else begin
                reload   = 1'b0;
                in_valid = 1'b1;
                in_data  = prog[idx];
                in_last  = has_last && (idx == n - 1);
                if (in_ready) begin
                    idx++;
                    acc++;
                    last_acc_cyc = cyc + 1;
                    stall = 0;
                    if (acc == exp_acc) chk_next = 1'b1;
                end else begin
                    stall++;
                end
            end
        end
        tick();
        if (chk_next) check("in_ready_after_last", in_ready, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reload   = 1'b0;
        check("bytes_accepted", acc, exp_acc);
    endtask

    task automatic finish_check();
        int bound, exp_rise;
        bound = 0;
        while (!START && bound < 100) begin
            tick();
            bound++;
        end
        check("start_timeout", START, 1'b1);
        exp_rise = last_acc_cyc + 1 + ((exp_k == IM_DEPTH - 1) ? 0 : (IM_DEPTH - 1 - exp_k));
        check("start_rise_cycle", start_rise, exp_rise);
        check("last_word_write_cycle", wr_cyc[exp_k], last_acc_cyc);
        check("word_count", word_count, exp_wc);
        check("err_partial", err_partial, exp_partial);
        check("err_ovf", err_ovf, exp_ovf);
        repeat (3) tick();
        check("write_count", wr_count, IM_DEPTH);
        check("start_held", START, 1'b1);
        for (int i = 0; i < IM_DEPTH; i++)
            check($sformatf("mem[%0d]", i), mem_cap[i], exp_mem[i]);
    endtask

    task automatic do_reload();
        tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_start_low", START, 1'b0);
        check("reload_in_ready", in_ready, 1'b1);
        check("reload_word_count", word_count, 0);
        check("reload_err_partial", err_partial, 1'b0);
        check("reload_err_ovf", err_ovf, 1'b0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_in_ready"}, in_ready, 1'b0);
        check({pfx, "_im_we"}, im_we, 1'b0);
        check({pfx, "_im_addr"}, im_addr, 0);
        check({pfx, "_im_wdata"}, im_wdata, 0);
        check({pfx, "_START"}, START, 1'b0);
        check({pfx, "_word_count"}, word_count, 0);
        check({pfx, "_err_partial"}, err_partial, 1'b0);
        check({pfx, "_err_ovf"}, err_ovf, 1'b0);
    endtask

    initial begin
        int b, wc_hold;
        // reset state
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RST = 1'b0;
        #1 check("idle_in_ready", in_ready, 1'b0);

        // basic three-word program, back-to-back bytes
        prog.delete();
        push_word(32'h0022_1820);
        push_word(32'h0022_1822);
        push_word(32'h0022_182A);
        send_bytes(1'b1, 0);
        finish_check();

        // same program with alternate idle cycles
        do_reload();
        send_bytes(1'b1, 1);
        finish_check();

        // partial final word
        do_reload();
        prog.delete();
        prog.push_back(8'hAA); prog.push_back(8'hBB); prog.push_back(8'hCC);
        prog.push_back(8'hDD); prog.push_back(8'h11);
        send_bytes(1'b1, 0);
        finish_check();

        // overflow: 33 words, no in_last
        do_reload();
        prog.delete();
        for (int i = 0; i < 33; i++) push_word($urandom);
        send_bytes(1'b0, 0);
        finish_check();

        // reload clears flags, then a single word
        do_reload();
        prog.delete();
        push_word(32'h1234_5678);
        send_bytes(1'b1, 0);
        finish_check();

        // random-length program with random gaps
        do_reload();
        prog.delete();
        b = $urandom_range(1, 60);
        for (int i = 0; i < b; i++) prog.push_back(8'($urandom));
        send_bytes(1'b1, 2);
        finish_check();

        // exactly full memory with in_last on the final byte
        do_reload();
        prog.delete();
        for (int i = 0; i < 4 * IM_DEPTH; i++) prog.push_back(8'($urandom));
        send_bytes(1'b1, 0);
        finish_check();

        // reset during CLEAR
        do_reload();
        prog.delete();
        for (int i = 0; i < 4; i++) push_word($urandom);
        send_bytes(1'b1, 0);
        b = 0;
        while (!seen10 && b < 60) begin
            tick();
            b++;
        end
        check("saw_clear_addr10", seen10, 1'b1);
        #2 RST = 1'b1;
        #1 check_all_zero("midreset");
        wc_hold = wr_count;
        tick();
        check("midreset_no_write", im_we, 1'b0);
        check("midreset_write_count", wr_count, wc_hold);
        RST = 1'b0;
        #1 check("post_reset_idle", in_ready, 1'b0);
        tick();
        check("post_reset_load", in_ready, 1'b1);
        prog.delete();
        b = $urandom_range(4, 40);
        for (int i = 0; i < b; i++) prog.push_back(8'($urandom));
        send_bytes(1'b1, 2);
        finish_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
